dot_product_scheduler: RTL and testbench

//  Shares one productoEscalar engine (8-bit a/b, 16-bit result) among N_REQ requesters.
//  - Round-robin arbitration.
//  - Sequences the engine: start pulse, then LEN valid operand beats, then result capture.
//  - Returns the result to the granted requester.
//  - Sits between requester logic and the single dot-product datapath instance.

---
 rtl/dot_sched_pkg.sv | 19 +
 rtl/dot_product_scheduler_rr_arbiter.sv | 34 +++
 rtl/dot_product_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_dot_product_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_sched_pkg.sv
// Shared definitions for the dot-product scheduler: FSM state encoding and
// default datapath widths.
package dot_sched_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARB         = 3'd1,
    START       = 3'd2,
    STREAM      = 3'd3,
    DRAIN       = 3'd4,
    DRAIN_ABORT = 3'd5,
    DONE        = 3'd6
  } state_t;

  localparam int DW_DEF   = 8;
  localparam int RW_DEF   = 16;
  localparam int LENW_DEF = 4;

endpackage

// File: rtl/dot_product_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping around.
// Purely combinational; the caller registers the result and advances ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTRW  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTRW-1:0]  idx,
  output logic             valid
);

  int slot;

  // Scan from the farthest slot back to ptr so the nearest request wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    slot  = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      slot = int'(ptr) + off;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (req[slot]) begin
        grant       = '0;
        grant[slot] = 1'b1;
        idx         = PTRW'(slot);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Shares one dot-product engine among N_REQ requesters with round-robin grant.
// Define DOTSCHED_TIMEOUT_EN to abort a job after TO_CYCLES beat-less STREAM cycles.
module dot_product_scheduler
  import dot_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = DW_DEF,
  parameter int RW        = RW_DEF,
  parameter int LENW      = LENW_DEF,
  parameter int TO_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*LENW-1:0] len,
  input  logic [N_REQ-1:0]      op_valid,
  input  logic [N_REQ*DW-1:0]   op_a,
  input  logic [N_REQ*DW-1:0]   op_b,
  output logic [N_REQ-1:0]      grant,
  output logic                  op_ready,
  output logic                  done,
  output logic                  err,
  output logic [RW-1:0]         res,
  output logic                  eng_start,
  output logic                  eng_valid,
  output logic [DW-1:0]         eng_a,
  output logic [DW-1:0]         eng_b,
  input  logic [RW-1:0]         eng_result,
  input  logic                  eng_busy
);

  localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(N_REQ - 1);

  logic [DW-1:0]   a_arr   [N_REQ];
  logic [DW-1:0]   b_arr   [N_REQ];
  logic [LENW-1:0] len_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi]   = op_a[gi*DW +: DW];
      assign b_arr[gi]   = op_b[gi*DW +: DW];
      assign len_arr[gi] = len[gi*LENW +: LENW];
    end
  endgenerate

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTRW-1:0]  owner_q, owner_d;
  logic [PTRW-1:0]  rr_q, rr_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    res_q, res_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] arb_grant;
  logic [PTRW-1:0]  arb_idx;
  logic             arb_valid;
  logic             owner_req;
  logic             beat;

  rr_arbiter #(.N_REQ(N_REQ), .PTRW(PTRW)) u_arb (
    .req   (req),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign owner_req = req[owner_q];
  // A beat needs the owner still requesting; a dropping req aborts instead.
  assign beat      = (state_q == STREAM) && op_valid[owner_q] && owner_req;

`ifdef DOTSCHED_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = 1'b0;
`ifdef DOTSCHED_TIMEOUT_EN
    stall_d = stall_q;
`endif
    unique case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        cnt_d = '0;
        if (arb_valid) begin
          grant_d = arb_grant;
          owner_d = arb_idx;
          len_d   = len_arr[arb_idx];
          rr_d    = (arb_idx == LAST_IDX) ? '0 : arb_idx + PTRW'(1);
          if (len_arr[arb_idx] == '0) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = START;
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d = '0;
`ifdef DOTSCHED_TIMEOUT_EN
        stall_d = '0;
`endif
        if (!owner_req) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = DRAIN_ABORT;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!owner_req) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = DRAIN_ABORT;
        end else if (beat) begin
          cnt_d = cnt_q + LENW'(1);
`ifdef DOTSCHED_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == len_q - LENW'(1)) state_d = DRAIN;
        end
`ifdef DOTSCHED_TIMEOUT_EN
        else if (stall_q == SW'(TO_CYCLES - 1)) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = DRAIN_ABORT;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      DRAIN: begin
        if (!eng_busy) begin
          res_d   = eng_result;
          state_d = DONE;
        end
      end
      DRAIN_ABORT: if (!eng_busy) state_d = IDLE;
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef DOTSCHED_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef DOTSCHED_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign op_ready  = (state_q == STREAM);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign res       = res_q;
  assign eng_start = (state_q == START);
  assign eng_valid = beat;
  assign eng_a     = beat ? a_arr[owner_q] : '0;
  assign eng_b     = beat ? b_arr[owner_q] : '0;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler with a behavioural accumulate engine
// and a scoreboard of expected done/err results.
module tb_dot_product_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*4-1:0] len = '0;
  logic [N-1:0]  op_valid = '0;
  logic [N*8-1:0] op_a = '0;
  logic [N*8-1:0] op_b = '0;
  logic [N-1:0]  grant;
  logic          op_ready, done, err, eng_start, eng_valid, eng_busy;
  logic [15:0]   res, eng_result;
  logic [7:0]    eng_a, eng_b;

  always #5 clk = ~clk;

  dot_product_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .op_valid   (op_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .grant      (grant),
    .op_ready   (op_ready),
    .done       (done),
    .err        (err),
    .res        (res),
    .eng_start  (eng_start),
    .eng_valid  (eng_valid),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_result (eng_result),
    .eng_busy   (eng_busy)
  );

  // Engine model: registered multiply, accumulate one cycle later (busy meanwhile).
  logic        prod_v_q;
  logic [15:0] prod_q, acc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_v_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
    end else begin
      if (eng_start)     acc_q <= '0;
      else if (prod_v_q) acc_q <= acc_q + prod_q;
      prod_v_q <= eng_valid;
      prod_q   <= 16'(eng_a) * 16'(eng_b);
    end
  end
  assign eng_busy   = prod_v_q;
  assign eng_result = acc_q;

  typedef struct {
    logic        is_err;
    logic [3:0]  grant;
    logic [15:0] res;
  } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;
  int start_cnt = 0, valid_cnt = 0, done_cnt = 0;
  logic [7:0] va [N][16];
  logic [7:0] vb [N][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done/err pulse pops one expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (eng_start) start_cnt++;
      if (eng_valid) valid_cnt++;
      if (done) done_cnt++;
      if (done || err) begin
        if (sb.size() == 0) begin
          check("unexpected_done_err", 32'(done) | (32'(err) << 1), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind_err", 32'(err), 32'(e.is_err));
          check("pulse_kind_done", 32'(done), 32'(!e.is_err));
          if (!e.is_err) check("done_grant", 32'(grant), 32'(e.grant));
          else           check("err_grant_cleared", 32'(grant), 32'h0);
          check(e.is_err ? "err_res_held" : "done_res", 32'(res), 32'(e.res));
          $display("[TB] t=%0t %s grant=%b res=%0d", $time, err ? "err " : "done", grant, res);
        end
      end
    end
  end

  function automatic logic [15:0] dot(input int idx, input int n);
    logic [15:0] s = '0;
    for (int k = 0; k < n; k++) s = s + 16'(va[idx][k]) * 16'(vb[idx][k]);
    return s;
  endfunction

  task automatic push(input logic is_err, input logic [3:0] g, input logic [15:0] r);
    exp_t e;
    e.is_err = is_err;
    e.grant  = g;
    e.res    = r;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    op_valid = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_op_ready"}, 32'(op_ready), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_res"}, 32'(res), 0);
    check({tag, "_eng_start"}, 32'(eng_start), 0);
    check({tag, "_eng_valid"}, 32'(eng_valid), 0);
    check({tag, "_eng_ab"}, {16'h0, eng_a, eng_b}, 0);
  endtask

  task automatic raise(input int idx, input int n);
    len[idx*4 +: 4] = 4'(n);
    req[idx] = 1'b1;
  endtask

  // Wait for grant, stream n beats (valid every gap+1 ready cycles), wait for done.
  task automatic serve(input int idx, input int n, input int gap, input int drop_after);
    int k = 0;
    int c = 0;
    int t = 0;
    while (!grant[idx] && t < 50) begin tick(); t++; end
    if (!grant[idx]) begin
      check("grant_timeout", 32'(grant), 32'(1 << idx));
      req[idx] = 1'b0;
      return;
    end
    t = 0;
    while (k < n && t < 500) begin
      if (drop_after > 0 && k == drop_after) break;
      if (op_ready) begin
        op_valid[idx] = ((c % (gap + 1)) == 0);
        op_a[idx*8 +: 8] = va[idx][k];
        op_b[idx*8 +: 8] = vb[idx][k];
        if (op_valid[idx]) k++;
        c++;
      end else begin
        op_valid[idx] = 1'b0;
      end
      tick();
      t++;
    end
    op_valid[idx] = 1'b0;
    if (drop_after > 0) begin
      req[idx] = 1'b0;
      t = 0;
      while (!err && t < 20) begin tick(); t++; end
      if (!err) check("err_timeout", 0, 1);
      repeat (3) tick();
      return;
    end
    if (n > 0) check("op_ready_low_after_last", 32'(op_ready), 0);
    t = 0;
    while (!done && t < 50) begin tick(); t++; end
    if (!done) check("done_timeout", 0, 1);
    req[idx] = 1'b0;
    tick();
  endtask

  initial begin
    int s0, v0, d0, t;
    do_reset();
    check_all_zero("reset");

    // 1: single job, four back-to-back beats
    for (int k = 0; k < 4; k++) begin va[0][k] = 8'(3 + 2*k); vb[0][k] = 8'(4 + 2*k); end
    push(1'b0, 4'b0001, dot(0, 4));
    check("dot_188_model", 32'(dot(0, 4)), 32'd188);
    s0 = start_cnt; v0 = valid_cnt; d0 = done_cnt;
    raise(0, 4);
    serve(0, 4, 0, 0);
    tick();
    check("t1_eng_start_count", 32'(start_cnt - s0), 1);
    check("t1_eng_valid_count", 32'(valid_cnt - v0), 4);
    check("t1_done_count", 32'(done_cnt - d0), 1);

    // 2: simultaneous requests 0 and 2, round robin from a fresh pointer
    do_reset();
    va[0][0] = 1; vb[0][0] = 1; va[0][1] = 2; vb[0][1] = 2;
    va[2][0] = 3; vb[2][0] = 3; va[2][1] = 4; vb[2][1] = 4;
    push(1'b0, 4'b0001, 16'd5);
    push(1'b0, 4'b0100, 16'd25);
    raise(0, 2);
    raise(2, 2);
    serve(0, 2, 0, 0);
    serve(2, 2, 0, 0);

    // 3: zero-length job never starts the engine
    push(1'b0, 4'b0010, 16'd0);
    s0 = start_cnt;
    raise(1, 0);
    serve(1, 0, 0, 0);
    check("t3_no_eng_start", 32'(start_cnt - s0), 0);

    // 4: gapped beats; a non-owner's op_valid is ignored
    for (int k = 0; k < 3; k++) begin va[3][k] = 8'(2 + 2*k); vb[3][k] = 8'(3 + 2*k); end
    push(1'b0, 4'b1000, 16'd68);
    v0 = valid_cnt;
    op_valid[1] = 1'b1;
    op_a[15:8] = 8'hFF;
    op_b[15:8] = 8'hFF;
    raise(3, 3);
    serve(3, 3, 2, 0);
    op_valid[1] = 1'b0;
    check("t4_eng_valid_count", 32'(valid_cnt - v0), 3);

    // 6: owner drops req after two beats
    for (int k = 0; k < 4; k++) begin va[0][k] = 8'(k + 1); vb[0][k] = 8'(k + 1); end
    push(1'b1, 4'b0000, 16'd68);
    raise(0, 4);
    serve(0, 4, 0, 2);

    // 5: reset in the middle of STREAM, then pointer must restart at 0
    for (int k = 0; k < 4; k++) begin va[2][k] = 8'(k + 7); vb[2][k] = 8'(k + 2); end
    raise(2, 4);
    t = 0;
    while (!op_ready && t < 20) begin tick(); t++; end
    for (int k = 0; k < 2; k++) begin
      op_valid[2] = 1'b1;
      op_a[23:16] = va[2][k];
      op_b[23:16] = vb[2][k];
      tick();
    end
    check("t5_still_streaming", 32'(op_ready), 1);
    #1 reset = 1'b0;
    #1 check_all_zero("midreset");
    op_valid = '0;
    req = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    va[1][0] = 5; vb[1][0] = 5;
    va[3][0] = 2; vb[3][0] = 3;
    push(1'b0, 4'b0010, 16'd25);
    push(1'b0, 4'b1000, 16'd6);
    raise(1, 1);
    raise(3, 1);
    serve(1, 1, 0, 0);
    serve(3, 1, 0, 0);

`ifdef DOTSCHED_TIMEOUT_EN
    // Stall abort: granted job that never offers a beat
    push(1'b1, 4'b0000, 16'd6);
    raise(0, 2);
    t = 0;
    while (!err && t < 200) begin tick(); t++; end
    check("timeout_err_seen", 32'(err), 1);
    req[0] = 1'b0;
    repeat (4) tick();
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
